// File: rtl/res_rd_pkg.sv
// Shared types and defaults for the result-cache argmax reader.
// RES_TOP2_EN adds runner-up tracking in the argmax unit and top level.
package res_rd_pkg;

    localparam int NUM_CLASS = 1000;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int RD_LAT    = 2;
    localparam int PARK_ADDR = 1000;

    typedef enum logic [2:0] {
        BOOT,
        IDLE,
        SWEEP,
        DRAIN,
        PARK,
        OUT
    } state_t;

    typedef logic signed [DATA_W-1:0] score_t;

    localparam score_t SCORE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic logic beats(score_t a, score_t b);
        return a > b;
    endfunction

endpackage

// File: rtl/res_argmax_unit.sv
// Compare-and-update registers for the running top-1 score.
// RES_TOP2_EN also keeps the runner-up.
module res_argmax_unit
    import res_rd_pkg::*;
(
    input  logic              clk_200M,
    input  logic              rst,
    input  logic              clr,
    input  logic              smp,
    input  score_t            score,
    input  logic [ADDR_W-1:0] idx,
`ifdef RES_TOP2_EN
    output logic [ADDR_W-1:0] sec_idx,
    output score_t            sec_score,
`endif
    output logic [ADDR_W-1:0] best_idx,
    output score_t            best_score
);

    logic first;

    always_ff @(posedge clk_200M) begin
        if (rst || clr) begin
            best_idx   <= '0;
            best_score <= SCORE_MIN;
            first      <= 1'b1;
`ifdef RES_TOP2_EN
            sec_idx    <= '0;
            sec_score  <= SCORE_MIN;
`endif
        end else if (smp) begin
            // strict compare: equal scores keep the earlier index
            if (first || beats(score, best_score)) begin
                best_idx   <= idx;
                best_score <= score;
                first      <= 1'b0;
`ifdef RES_TOP2_EN
                sec_idx    <= best_idx;
                sec_score  <= best_score;
`endif
            end
`ifdef RES_TOP2_EN
            else if (beats(score, sec_score)) begin
                sec_idx   <= idx;
                sec_score <= score;
            end
`endif
        end
    end

endmodule

// File: rtl/res_argmax_reader.sv
// Sweeps the finished result bank, reports top-1 over valid/ready.
// RES_TOP2_EN adds top2_idx/top2_score outputs.
module res_argmax_reader #(
    parameter int NUM_CLASS = res_rd_pkg::NUM_CLASS,
    parameter int ADDR_W    = res_rd_pkg::ADDR_W,
    parameter int DATA_W    = res_rd_pkg::DATA_W,
    parameter int RD_LAT    = res_rd_pkg::RD_LAT,
    parameter int PARK_ADDR = res_rd_pkg::PARK_ADDR
) (
    input  logic              clk_200M,
    input  logic              rst,
    input  logic              calc_finish_pulse,
    input  logic [DATA_W-1:0] calc_res_out,
    output logic [ADDR_W-1:0] calc_res_ram_addr,
    output logic [ADDR_W-1:0] top1_idx,
    output logic [DATA_W-1:0] top1_score,
`ifdef RES_TOP2_EN
    output logic [ADDR_W-1:0] top2_idx,
    output logic [DATA_W-1:0] top2_score,
`endif
    output logic              top_vld,
    input  logic              top_rdy,
    output logic              busy,
    output logic [15:0]       ovr_cnt
);

    import res_rd_pkg::*;

    localparam int DCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NUM_CLASS - 1);
    localparam logic [ADDR_W-1:0] PARK_A = ADDR_W'(PARK_ADDR);
    localparam logic [DCW-1:0]    LAST_D = DCW'(RD_LAT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DCW-1:0]    dcnt;
    logic [DCW-1:0]    dcnt_nxt;
    logic              vld_nxt;
    logic              clr;
    logic              ld;

    logic              pv [RD_LAT];
    logic [ADDR_W-1:0] pi [RD_LAT];

    logic [ADDR_W-1:0] best_idx;
    score_t            best_score;
`ifdef RES_TOP2_EN
    logic [ADDR_W-1:0] sec_idx;
    score_t            sec_score;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk_200M) begin
        if (rst) begin
            state             <= BOOT;
            calc_res_ram_addr <= '0;
            dcnt              <= '0;
            top_vld           <= 1'b0;
        end else begin
            state             <= state_nxt;
            calc_res_ram_addr <= addr_nxt;
            dcnt              <= dcnt_nxt;
            top_vld           <= vld_nxt;
        end
    end

    // addr is registered, so each state chooses the address of the next one
    always_comb begin
        state_nxt = state;
        addr_nxt  = '0;
        dcnt_nxt  = dcnt;
        vld_nxt   = top_vld;
        clr       = 1'b0;
        ld        = 1'b0;
        unique case (state)
            BOOT: begin
                if (calc_res_ram_addr == PARK_A) begin
                    state_nxt = IDLE;
                end else begin
                    addr_nxt = PARK_A;
                end
            end
            IDLE: begin
                if (calc_finish_pulse) begin
                    state_nxt = SWEEP;
                    clr       = 1'b1;
                end
            end
            SWEEP: begin
                if (calc_res_ram_addr == LAST_A) begin
                    state_nxt = DRAIN;
                    dcnt_nxt  = '0;
                end else begin
                    addr_nxt = calc_res_ram_addr + 1'b1;
                end
            end
            DRAIN: begin
                if (dcnt == LAST_D) begin
                    state_nxt = PARK;
                    addr_nxt  = PARK_A;
                end else begin
                    dcnt_nxt = dcnt + 1'b1;
                end
            end
            PARK: begin
                state_nxt = OUT;
                vld_nxt   = 1'b1;
                ld        = 1'b1;
            end
            OUT: begin
                if (top_vld && top_rdy) begin
                    state_nxt = IDLE;
                    vld_nxt   = 1'b0;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    // {valid, idx} travels with each address until its score arrives
    always_ff @(posedge clk_200M) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pv[i] <= 1'b0;
                pi[i] <= '0;
            end
        end else begin
            pv[0] <= (state == SWEEP);
            pi[0] <= calc_res_ram_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pi[i] <= pi[i-1];
            end
        end
    end

    res_argmax_unit u_argmax (
        .clk_200M   (clk_200M),
        .rst        (rst),
        .clr        (clr),
        .smp        (pv[RD_LAT-1]),
        .score      (score_t'(calc_res_out)),
        .idx        (pi[RD_LAT-1]),
`ifdef RES_TOP2_EN
        .sec_idx    (sec_idx),
        .sec_score  (sec_score),
`endif
        .best_idx   (best_idx),
        .best_score (best_score)
    );

    always_ff @(posedge clk_200M) begin
        if (rst) begin
            top1_idx   <= '0;
            top1_score <= '0;
`ifdef RES_TOP2_EN
            top2_idx   <= '0;
            top2_score <= '0;
`endif
        end else if (ld) begin
            top1_idx   <= best_idx;
            top1_score <= best_score;
`ifdef RES_TOP2_EN
            top2_idx   <= sec_idx;
            top2_score <= sec_score;
`endif
        end
    end

    always_ff @(posedge clk_200M) begin
        if (rst) begin
            ovr_cnt <= '0;
        end else if (calc_finish_pulse && state != IDLE && ovr_cnt != 16'hFFFF) begin
            ovr_cnt <= ovr_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_res_argmax_reader.sv
// Scoreboard bench for res_argmax_reader with a 2-cycle cache model.
// Build with RES_TOP2_EN to also cover the runner-up outputs.
module tb_res_argmax_reader;

    logic        clk_200M = 1'b0;
    logic        rst;
    logic        calc_finish_pulse;
    logic [31:0] calc_res_out;
    logic [9:0]  calc_res_ram_addr;
    logic [9:0]  top1_idx;
    logic [31:0] top1_score;
`ifdef RES_TOP2_EN
    logic [9:0]  top2_idx;
    logic [31:0] top2_score;
`endif
    logic        top_vld;
    logic        top_rdy;
    logic        busy;
    logic [15:0] ovr_cnt;

    always #5 clk_200M = ~clk_200M;

    res_argmax_reader dut (
        .clk_200M          (clk_200M),
        .rst               (rst),
        .calc_finish_pulse (calc_finish_pulse),
        .calc_res_out      (calc_res_out),
        .calc_res_ram_addr (calc_res_ram_addr),
        .top1_idx          (top1_idx),
        .top1_score        (top1_score),
`ifdef RES_TOP2_EN
        .top2_idx          (top2_idx),
        .top2_score        (top2_score),
`endif
        .top_vld           (top_vld),
        .top_rdy           (top_rdy),
        .busy              (busy),
        .ovr_cnt           (ovr_cnt)
    );

    int mem [1000];
    logic [31:0] r1;
    logic [31:0] r2;

    always @(posedge clk_200M) begin
        r1 <= (calc_res_ram_addr < 10'd1000) ? mem[calc_res_ram_addr] : 32'h0;
        r2 <= r1;
    end
    assign calc_res_out = r2;

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        ntot++;
        if (obs == exp) npass++;
        else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    endtask

    typedef struct {
        int i1;
        int s1;
        int i2;
        int s2;
    } exp_t;

    exp_t sbq[$];
    exp_t sb_e;

    function automatic exp_t model();
        exp_t e;
        e.i1 = 0;
        e.s1 = mem[0];
        for (int i = 1; i < 1000; i++)
            if (mem[i] > e.s1) begin
                e.i1 = i;
                e.s1 = mem[i];
            end
        e.i2 = -1;
        e.s2 = 0;
        for (int i = 0; i < 1000; i++)
            if (i != e.i1 && (e.i2 < 0 || mem[i] > e.s2)) begin
                e.i2 = i;
                e.s2 = mem[i];
            end
        return e;
    endfunction

    logic prev_vld = 1'b0;

    always @(negedge clk_200M) begin
        if (!rst && top_vld && !prev_vld) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                sb_e = sbq.pop_front();
                chk("top1_idx", top1_idx, sb_e.i1);
                chk("top1_score", $signed(top1_score), sb_e.s1);
`ifdef RES_TOP2_EN
                chk("top2_idx", top2_idx, sb_e.i2);
                chk("top2_score", $signed(top2_score), sb_e.s2);
`endif
            end
        end
        prev_vld = top_vld;
    end

    int   park_total = 0;
    int   bad_addr   = 0;
    int   dbl_park   = 0;
    logic prev_park  = 1'b0;

    always @(negedge clk_200M) begin
        if (!rst) begin
            if (calc_res_ram_addr > 10'd1000) bad_addr++;
            if (calc_res_ram_addr == 10'd1000) begin
                park_total++;
                if (prev_park) dbl_park++;
            end
            prev_park = (calc_res_ram_addr == 10'd1000);
        end else begin
            prev_park = 1'b0;
        end
    end

    int exp_ovr = 0;

    task automatic run_frame(input string nm, input int hold, input int ovr_at);
        int          n;
        int          p0;
        logic        ov;
        logic        stable;
        logic [9:0]  hi;
        logic [31:0] hs;
        sbq.push_back(model());
        p0 = park_total;
        top_rdy = (hold == 0);
        calc_finish_pulse = 1'b1;
        @(negedge clk_200M);
        calc_finish_pulse = 1'b0;
        n  = 1;
        ov = 1'b0;
        while (!top_vld && n < 3000) begin
            calc_finish_pulse = (ovr_at >= 0) && !ov && busy
                                && (calc_res_ram_addr == 10'(ovr_at));
            if (calc_finish_pulse) ov = 1'b1;
            @(negedge clk_200M);
            n++;
        end
        calc_finish_pulse = 1'b0;
        chk({nm, "_latency"}, n, 1004);
        if (hold > 0) begin
            hi = top1_idx;
            hs = top1_score;
            stable = 1'b1;
            repeat (hold) begin
                @(negedge clk_200M);
                if (!top_vld || top1_idx != hi || top1_score != hs) stable = 1'b0;
            end
            chk({nm, "_bp_stable"}, stable, 1);
            top_rdy = 1'b1;
        end
        @(negedge clk_200M);
        chk({nm, "_vld_drop"}, top_vld, 0);
        chk({nm, "_idle"}, busy, 0);
        chk({nm, "_park_once"}, park_total - p0, 1);
        chk({nm, "_ovr"}, ovr_cnt, exp_ovr);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        calc_finish_pulse = 1'b0;
        top_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) mem[i] = 0;
        repeat (3) @(negedge clk_200M);
        chk("rst_addr", calc_res_ram_addr, 0);
        chk("rst_busy", busy, 1);
        chk("rst_vld", top_vld, 0);
        chk("rst_ovr", ovr_cnt, 0);
        chk("rst_idx", top1_idx, 0);
        chk("rst_score", top1_score, 0);
        rst = 1'b0;
        @(negedge clk_200M);
        chk("boot_addr", calc_res_ram_addr, 1000);
        chk("boot_busy", busy, 1);
        @(negedge clk_200M);
        chk("idle_addr", calc_res_ram_addr, 0);
        chk("idle_busy", busy, 0);
        chk("idle_vld", top_vld, 0);

        for (int i = 0; i < 1000; i++) mem[i] = i;
        run_frame("ramp", 0, -1);
        chk("ramp_idx", top1_idx, 999);
        chk("ramp_score", $signed(top1_score), 999);

        for (int i = 0; i < 1000; i++) mem[i] = -5;
        mem[17]  = 3;
        mem[400] = 3;
        run_frame("ties", 0, -1);
        chk("ties_idx", top1_idx, 17);
        chk("ties_score", $signed(top1_score), 3);

        for (int i = 0; i < 1000; i++)
            mem[i] = int'($urandom_range(2000000, 0)) - 1000000;
        run_frame("bp", 50, -1);

        for (int i = 0; i < 1000; i++)
            mem[i] = int'($urandom_range(2000000, 0)) - 1000000;
        exp_ovr = 1;
        run_frame("ovr", 0, 300);

        calc_finish_pulse = 1'b1;
        @(negedge clk_200M);
        calc_finish_pulse = 1'b0;
        n = 0;
        while (calc_res_ram_addr != 10'd500 && n < 2000) begin
            @(negedge clk_200M);
            n++;
        end
        chk("abort_reach", calc_res_ram_addr, 500);
        rst = 1'b1;
        @(negedge clk_200M);
        chk("abort_vld", top_vld, 0);
        chk("abort_addr", calc_res_ram_addr, 0);
        chk("abort_busy", busy, 1);
        chk("abort_ovr", ovr_cnt, 0);
        exp_ovr = 0;
        rst = 1'b0;
        @(negedge clk_200M);
        chk("reboot_addr", calc_res_ram_addr, 1000);
        @(negedge clk_200M);
        chk("reboot_idle", busy, 0);

        for (int i = 0; i < 1000; i++)
            mem[i] = -int'($urandom_range(1000000, 1));
        run_frame("neg", 0, -1);

`ifdef RES_TOP2_EN
        for (int i = 0; i < 1000; i++) mem[i] = 0;
        mem[5]   = 100;
        mem[9]   = 100;
        mem[700] = 90;
        run_frame("top2", 0, -1);
        chk("t2_top1_idx", top1_idx, 5);
        chk("t2_top2_idx", top2_idx, 9);
        chk("t2_top2_score", $signed(top2_score), 100);
`endif

        chk("addr_range", bad_addr, 0);
        chk("park_consec", dbl_park, 0);
        chk("sb_leftover", sbq.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
